vinsn_issue_queue: RTL and testbench
====================================

Name: vinsn_issue_queue

Overview:
- Decoupling buffer between `vinsn_decoder` (upstream) and `vinsn_launcher` (downstream).
- Accepts decoded `issue_req_t` beats, stamps each one with a free instruction ID, and stores it in an in-order FIFO. It then presents the FIFO head to the launcher with a valid/ready handshake.
- Tracks in-flight IDs and recycles them when the commit controller reports completion. It back-pressures the decoder when either the FIFO is full or no ID is free.

Parameters:
- Depth, 4, FIFO entries; power of two, ≥2.
- NrIDs, InsnIDNum (core_pkg), number of instruction IDs; IDs are 0..NrIDs-1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- dec_valid_i  in  1  decoder has a request.
- dec_ready_o  out  1  queue accepts the request this cycle.
- dec_req_i  in  issue_req_t  decoded request; its insn_id field is ignored.
- issue_req_valid_o  out  1  head entry is valid, toward the launcher.
- issue_req_ready_i  in  1  launcher accepts the head.
- issue_req_o  out  issue_req_t  head entry; insn_id = allocated ID.
- alloc_valid_o  out  1  pulse: an ID was allocated this cycle.
- alloc_id_o  out  insn_id_t  ID allocated this cycle, for the commit controller.
- done_i  in  1  an instruction retired.
- done_insn_id_i  in  insn_id_t  ID of the retired instruction.
- flush_i  in  1  discard all queued (not-yet-launched) entries.
- occupancy_o  out  $clog2(Depth)+1  entries currently stored.

Behaviour:
- Reset (async, rst_ni low):
  - FIFO is empty; read and write pointers are 0; occupancy_o=0.
  - issue_req_valid_o=0, alloc_valid_o=0, alloc_id_o=0.
  - All IDs are free; the ID search pointer is 0.
  - Reset mid-operation drops all entries and in-flight tracking immediately.
- ID allocation:
  - A busy bit vector of NrIDs bits tracks IDs in flight.
  - The next ID is the lowest free ID at or after the search pointer, searching round-robin and wrapping from NrIDs-1 to 0.
  - The search pointer advances to allocated ID+1, mod NrIDs.
- dec_ready_o = !full && any ID free && !flush_i. It is combinational and does not depend on dec_valid_i.
- Enqueue (dec_valid_i && dec_ready_o):
  - Write dec_req_i with insn_id replaced by the chosen ID into the write pointer slot; the write pointer wraps mod Depth.
  - Set that ID's busy bit.
  - alloc_valid_o=1 and alloc_id_o=ID, both combinational in the same cycle.
- Dequeue:
  - issue_req_valid_o = !empty; issue_req_o = the entry at the read pointer. Both are registered state, so there is no input-to-output combinational path.
  - Handshake valid && ready advances the read pointer.
  - Once asserted, valid and the data stay stable until the handshake or a flush.
- Latency: an enqueue at cycle N is visible at the head at N+1 at the earliest; there is no bypass.
- Enqueue and dequeue in the same cycle:
  - Allowed when full, because the slot is freed the same cycle; dec_ready_o treats full as relieved if issue_req_ready_i && issue_req_valid_o.
  - Occupancy is unchanged.
- Release: done_i clears busy[done_insn_id_i] at the clock edge.
  - Release of an ID being allocated in the same cycle cannot occur, because an allocated ID is never free.
  - done_i on an ID that is not busy is ignored; the bench asserts this never happens.
  - A released ID is allocatable in the next cycle, not the same one.
- Flush:
  - On flush_i, the pointers reset to equal and occupancy goes to 0 at the edge.
  - Busy bits of every ID still stored in the FIFO are cleared.
  - IDs already handed to the launcher stay busy.
  - No enqueue happens during a flush cycle.
  - A dequeue handshake in the flush cycle still completes; that ID stays busy.
- occupancy_o is registered and ranges 0..Depth; full means occupancy == Depth, empty means occupancy == 0.

Test Plan:
- Reset, then 3 back-to-back enqueues, launcher ready=0 → IDs 0,1,2 allocated; occupancy_o=3; head insn_id=0 stable across 5 stall cycles.
- Fill Depth=4, launcher ready=0 → dec_ready_o=0. Next cycle, assert ready and dec_valid_i together → simultaneous enq/deq, occupancy stays 4, ID 4 allocated.
- NrIDs=8: 8 enqueues and dequeues, no done_i → dec_ready_o=0 with an empty FIFO. done_i with ID 5 → next cycle ID 5 is allocated.
- Wrap: 12 enq/deq pairs with immediate done_i → pointers wrap, data order preserved, IDs cycle 0..7,0..3.
- Queue holds IDs 2,3; ID 1 already launched; flush_i → occupancy 0, valid=0, IDs 2,3 free, ID 1 still busy. Next enqueue gets the next free ID after the search pointer.
- Assert rst_ni low while occupancy=3 → all outputs 0 asynchronously. After release, first allocation is ID 0.

Source files
------------

// File: rtl/vinsn_issue_queue.sv
// Instruction issue queue: stamps decoded requests with a free instruction ID,
// buffers them in order and hands the head to the launcher; IDs recycle on retire.

package core_pkg;
    localparam int unsigned InsnIDNum = 8;

    typedef logic [$clog2(InsnIDNum)-1:0] insn_id_t;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] operand;
        insn_id_t    insn_id;
    } issue_req_t;
endpackage

module vinsn_issue_queue
    import core_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned NrIDs = InsnIDNum
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    dec_valid_i,
    output logic                    dec_ready_o,
    input  issue_req_t              dec_req_i,
    output logic                    issue_req_valid_o,
    input  logic                    issue_req_ready_i,
    output issue_req_t              issue_req_o,
    output logic                    alloc_valid_o,
    output insn_id_t                alloc_id_o,
    input  logic                    done_i,
    input  insn_id_t                done_insn_id_i,
    input  logic                    flush_i,
    output logic [$clog2(Depth):0]  occupancy_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned OccW = PtrW + 1;
    localparam int unsigned IdW  = $bits(insn_id_t);

    issue_req_t      mem_reg [Depth];
    logic [PtrW-1:0] wr_ptr_reg;
    logic [PtrW-1:0] rd_ptr_reg;
    logic [OccW-1:0] occ_reg;
    logic [OccW-1:0] occ_next;
    logic            valid_reg;
    logic [NrIDs-1:0] busy_reg;
    logic [NrIDs-1:0] busy_next;
    insn_id_t        search_ptr_reg;

    logic            full;
    logic            deq;
    logic            enq;
    logic            free_found;
    insn_id_t        free_id;
    logic [IdW:0]    cand;
    issue_req_t      req_in;
    logic [Depth-1:0] slot_live;

    assign full = (occ_reg == OccW'(Depth));
    assign deq  = valid_reg && issue_req_ready_i;

    // A full queue can still accept when the head leaves in the same cycle.
    assign dec_ready_o = (!full || deq) && free_found && !flush_i;
    assign enq         = dec_valid_i && dec_ready_o;

    assign alloc_valid_o     = enq;
    assign alloc_id_o        = enq ? free_id : '0;
    assign issue_req_valid_o = valid_reg;
    assign issue_req_o       = mem_reg[rd_ptr_reg];
    assign occupancy_o       = occ_reg;

    // Round-robin search: scanning offsets downward leaves the lowest free offset last.
    always_comb begin
        free_found = 1'b0;
        free_id    = '0;
        cand       = '0;
        for (int k = NrIDs - 1; k >= 0; k--) begin
            cand = {1'b0, search_ptr_reg} + (IdW+1)'(k);
            if (cand >= (IdW+1)'(NrIDs)) begin
                cand = cand - (IdW+1)'(NrIDs);
            end
            if (!busy_reg[cand[IdW-1:0]]) begin
                free_found = 1'b1;
                free_id    = cand[IdW-1:0];
            end
        end
    end

    always_comb begin
        req_in         = dec_req_i;
        req_in.insn_id = free_id;
    end

    // Slots still holding unlaunched entries; the head leaving this cycle keeps its ID busy.
    for (genvar gi = 0; gi < Depth; gi++) begin : g_slot
        logic [PtrW-1:0] offs;
        assign offs          = PtrW'(gi) - rd_ptr_reg;
        assign slot_live[gi] = ({1'b0, offs} < occ_reg) && !(deq && (offs == '0));
    end

    always_comb begin
        busy_next = busy_reg;
        if (done_i) begin
            busy_next[done_insn_id_i] = 1'b0;
        end
        if (flush_i) begin
            for (int s = 0; s < Depth; s++) begin
                if (slot_live[s]) begin
                    busy_next[mem_reg[s].insn_id] = 1'b0;
                end
            end
        end
        if (enq) begin
            busy_next[free_id] = 1'b1;
        end
    end

    always_comb begin
        occ_next = occ_reg;
        if (flush_i) begin
            occ_next = '0;
        end else if (enq && !deq) begin
            occ_next = occ_reg + 1'b1;
        end else if (deq && !enq) begin
            occ_next = occ_reg - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            occ_reg        <= '0;
            valid_reg      <= 1'b0;
            busy_reg       <= '0;
            search_ptr_reg <= '0;
            for (int s = 0; s < Depth; s++) begin
                mem_reg[s] <= '0;
            end
        end else begin
            busy_reg  <= busy_next;
            occ_reg   <= occ_next;
            valid_reg <= (occ_next != '0);
            if (flush_i) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (enq) begin
                    mem_reg[wr_ptr_reg] <= req_in;
                    wr_ptr_reg          <= wr_ptr_reg + 1'b1;
                    search_ptr_reg      <= (free_id == IdW'(NrIDs - 1)) ? '0 : free_id + 1'b1;
                end
                if (deq) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vinsn_issue_queue.sv
// Directed bench for vinsn_issue_queue: allocation order, stalls, full enq/deq,
// ID exhaustion and release, pointer wrap, flush and asynchronous reset.

module tb_vinsn_issue_queue;
    import core_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       dec_valid_i = 1'b0;
    logic       dec_ready_o;
    issue_req_t dec_req_i = '0;
    logic       issue_req_valid_o;
    logic       issue_req_ready_i = 1'b0;
    issue_req_t issue_req_o;
    logic       alloc_valid_o;
    insn_id_t   alloc_id_o;
    logic       done_i = 1'b0;
    insn_id_t   done_insn_id_i = '0;
    logic       flush_i = 1'b0;
    logic [2:0] occupancy_o;

    int chk_cnt = 0;
    int err_cnt = 0;

    vinsn_issue_queue #(.Depth(4), .NrIDs(8)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .dec_valid_i       (dec_valid_i),
        .dec_ready_o       (dec_ready_o),
        .dec_req_i         (dec_req_i),
        .issue_req_valid_o (issue_req_valid_o),
        .issue_req_ready_i (issue_req_ready_i),
        .issue_req_o       (issue_req_o),
        .alloc_valid_o     (alloc_valid_o),
        .alloc_id_o        (alloc_id_o),
        .done_i            (done_i),
        .done_insn_id_i    (done_insn_id_i),
        .flush_i           (flush_i),
        .occupancy_o       (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        dec_valid_i = 1'b0;
        issue_req_ready_i = 1'b0;
        done_i = 1'b0;
        flush_i = 1'b0;
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    // insn_id is filled with junk to show the queue overwrites it
    function automatic issue_req_t mk_req(input logic [7:0] op, input logic [31:0] operand);
        issue_req_t r;
        r.op      = op;
        r.operand = operand;
        r.insn_id = 3'd6;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ids[7];
        exp_ids = '{4, 5, 6, 7, 0, 2, 3};

        // Reset state
        do_reset();
        check_eq("rst_valid", issue_req_valid_o, 0);
        check_eq("rst_occ", occupancy_o, 0);
        check_eq("rst_alloc_valid", alloc_valid_o, 0);
        check_eq("rst_alloc_id", alloc_id_o, 0);
        check_eq("rst_ready", dec_ready_o, 1);

        // Three back-to-back enqueues, launcher stalled
        for (int i = 0; i < 3; i++) begin
            dec_valid_i = 1'b1;
            dec_req_i = mk_req(8'(i), 32'h1000 + 32'(i));
            #1;
            check_eq($sformatf("t1_alloc_id%0d", i), alloc_id_o, 64'(i));
            check_eq($sformatf("t1_alloc_v%0d", i), alloc_valid_o, 1);
            if (i == 0) check_eq("t1_no_bypass", issue_req_valid_o, 0);
            tick();
        end
        dec_valid_i = 1'b0;
        #1;
        check_eq("t1_occ", occupancy_o, 3);
        for (int c = 0; c < 5; c++) begin
            check_eq($sformatf("t1_stall_valid%0d", c), issue_req_valid_o, 1);
            check_eq($sformatf("t1_stall_id%0d", c), issue_req_o.insn_id, 0);
            check_eq($sformatf("t1_stall_opnd%0d", c), issue_req_o.operand, 32'h1000);
            tick();
        end

        // Fill to Depth, then simultaneous enqueue/dequeue while full
        dec_valid_i = 1'b1;
        dec_req_i = mk_req(8'd3, 32'h1003);
        #1;
        check_eq("t2_alloc_id3", alloc_id_o, 3);
        tick();
        dec_req_i = mk_req(8'd4, 32'h1004);
        #1;
        check_eq("t2_full_occ", occupancy_o, 4);
        check_eq("t2_full_ready", dec_ready_o, 0);
        check_eq("t2_full_alloc_v", alloc_valid_o, 0);
        tick();
        issue_req_ready_i = 1'b1;
        #1;
        check_eq("t2_enqdeq_ready", dec_ready_o, 1);
        check_eq("t2_enqdeq_id", alloc_id_o, 4);
        tick();
        dec_valid_i = 1'b0;
        issue_req_ready_i = 1'b0;
        #1;
        check_eq("t2_enqdeq_occ", occupancy_o, 4);
        check_eq("t2_head_id", issue_req_o.insn_id, 1);

        // Drain, then exhaust all eight IDs without retiring any
        issue_req_ready_i = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            #1;
            check_eq($sformatf("t3_drain_id%0d", j), issue_req_o.insn_id, 64'(j));
            check_eq($sformatf("t3_drain_op%0d", j), issue_req_o.op, 64'(j));
            tick();
        end
        issue_req_ready_i = 1'b0;
        check_eq("t3_empty_valid", issue_req_valid_o, 0);
        for (int id = 5; id <= 7; id++) begin
            dec_valid_i = 1'b1;
            dec_req_i = mk_req(8'(id), 32'h2000 + 32'(id));
            #1;
            check_eq($sformatf("t3_alloc_id%0d", id), alloc_id_o, 64'(id));
            tick();
            dec_valid_i = 1'b0;
            issue_req_ready_i = 1'b1;
            #1;
            check_eq($sformatf("t3_head_id%0d", id), issue_req_o.insn_id, 64'(id));
            tick();
            issue_req_ready_i = 1'b0;
        end
        dec_valid_i = 1'b1;
        dec_req_i = mk_req(8'h55, 32'h3000);
        #1;
        check_eq("t3_noid_occ", occupancy_o, 0);
        check_eq("t3_noid_ready", dec_ready_o, 0);
        done_i = 1'b1;
        done_insn_id_i = 3'd5;
        #1;
        check_eq("t3_release_same_cycle", dec_ready_o, 0);
        tick();
        done_i = 1'b0;
        #1;
        check_eq("t3_release_ready", dec_ready_o, 1);
        check_eq("t3_release_id", alloc_id_o, 5);
        tick();
        dec_valid_i = 1'b0;

        // Twelve enqueue/dequeue pairs with immediate retire: pointer and ID wrap
        do_reset();
        for (int i = 0; i < 12; i++) begin
            dec_valid_i = 1'b1;
            dec_req_i = mk_req(8'(i + 16), 32'hA500_0000 + 32'(i));
            #1;
            check_eq($sformatf("t4_alloc_id%0d", i), alloc_id_o, 64'(i % 8));
            tick();
            dec_valid_i = 1'b0;
            issue_req_ready_i = 1'b1;
            done_i = 1'b1;
            done_insn_id_i = 3'(i % 8);
            #1;
            check_eq($sformatf("t4_head_opnd%0d", i), issue_req_o.operand, 32'hA500_0000 + 32'(i));
            check_eq($sformatf("t4_head_id%0d", i), issue_req_o.insn_id, 64'(i % 8));
            tick();
            issue_req_ready_i = 1'b0;
            done_i = 1'b0;
        end
        check_eq("t4_end_occ", occupancy_o, 0);

        // Flush with IDs 2,3 queued and ID 1 already launched
        do_reset();
        for (int i = 0; i < 4; i++) begin
            dec_valid_i = 1'b1;
            dec_req_i = mk_req(8'(i + 32), 32'hB000 + 32'(i));
            #1;
            tick();
        end
        dec_valid_i = 1'b0;
        issue_req_ready_i = 1'b1;
        done_i = 1'b1;
        done_insn_id_i = 3'd0;
        #1;
        check_eq("t5_head0", issue_req_o.insn_id, 0);
        tick();
        done_i = 1'b0;
        #1;
        check_eq("t5_head1", issue_req_o.insn_id, 1);
        tick();
        issue_req_ready_i = 1'b0;
        check_eq("t5_pre_occ", occupancy_o, 2);
        flush_i = 1'b1;
        dec_valid_i = 1'b1;
        dec_req_i = mk_req(8'h77, 32'hB077);
        #1;
        check_eq("t5_flush_ready", dec_ready_o, 0);
        check_eq("t5_flush_alloc_v", alloc_valid_o, 0);
        tick();
        flush_i = 1'b0;
        dec_valid_i = 1'b0;
        #1;
        check_eq("t5_post_occ", occupancy_o, 0);
        check_eq("t5_post_valid", issue_req_valid_o, 0);
        dec_valid_i = 1'b1;
        issue_req_ready_i = 1'b1;
        for (int k = 0; k < 7; k++) begin
            dec_req_i = mk_req(8'(k + 48), 32'hC000 + 32'(k));
            #1;
            check_eq($sformatf("t5_alloc%0d", k), alloc_id_o, 64'(exp_ids[k]));
            tick();
        end
        #1;
        check_eq("t5_id1_busy_ready", dec_ready_o, 0);
        dec_valid_i = 1'b0;
        issue_req_ready_i = 1'b0;
        tick();

        // Asynchronous reset mid-operation
        do_reset();
        for (int i = 0; i < 3; i++) begin
            dec_valid_i = 1'b1;
            dec_req_i = mk_req(8'(i + 64), 32'hD000 + 32'(i));
            #1;
            tick();
        end
        dec_valid_i = 1'b0;
        check_eq("t6_pre_occ", occupancy_o, 3);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("t6_async_valid", issue_req_valid_o, 0);
        check_eq("t6_async_occ", occupancy_o, 0);
        check_eq("t6_async_data", issue_req_o, 0);
        check_eq("t6_async_alloc_v", alloc_valid_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();
        dec_valid_i = 1'b1;
        dec_req_i = mk_req(8'h99, 32'hE000);
        #1;
        check_eq("t6_first_id", alloc_id_o, 0);
        check_eq("t6_first_alloc_v", alloc_valid_o, 1);
        tick();
        dec_valid_i = 1'b0;
        #1;
        check_eq("t6_first_head", issue_req_o.operand, 32'hE000);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
